control_unit: RTL and testbench

- Multi-cycle sequencer that drives every control strobe of the data unit from its OPCODE, STATUS and STATUS_SEL outputs.
- Implements fetch, decode and execute for the 5-bit opcode set.
- Uses a microstep counter for the two- and three-cycle memory, call and return instructions.
- Sits directly upstream of the data unit; purely a controller, it holds no datapath registers.

---
 rtl/control_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_control_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving the data unit's control strobes.
// Optional macro SINGLE_STEP_EN adds a STEP input that gates each instruction fetch.
module control_unit #(
    parameter logic [3:0] ALU_PASS_A = 4'b1110,
    parameter logic [3:0] ALU_PASS_B = 4'b1111,
    parameter int         RAM_STACK  = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [4:0] OPCODE,
    input  logic [7:0] STATUS,
    input  logic [2:0] STATUS_SEL,
`ifdef SINGLE_STEP_EN
    input  logic       STEP,
`endif
    output logic [3:0] ALU_OPERATION,
    output logic       INC_PROGCOUNT,
    output logic       CLR_PROGCOUNT,
    output logic       WRITE_PROGCOUNT,
    output logic       READ_PROGCOUNT,
    output logic       WRITE_INSTREG,
    output logic       WRITE_REGS,
    output logic       USE_IMMEDIATE,
    output logic       USE_DISPLACEMENT,
    output logic       WRITE_MEM,
    output logic       READ_MEM,
    output logic       WRITE_MEMADDR,
    output logic       WRITE_STATREG,
    output logic       CLR_STATBIT,
    output logic       SET_STATBIT,
    output logic       PRESET_STACKPTR,
    output logic       INC_STACKPTR,
    output logic       DEC_STACKPTR,
    output logic       READ_STACKPTR,
    output logic       HALTED
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [4:0] OP_HALT = 5'b00001;
    localparam logic [4:0] OP_MOV  = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_LD   = 5'b00100;
    localparam logic [4:0] OP_ST   = 5'b00101;
    localparam logic [4:0] OP_JMP  = 5'b10000;
    localparam logic [4:0] OP_BRS  = 5'b10001;
    localparam logic [4:0] OP_BRC  = 5'b10010;
    localparam logic [4:0] OP_SETB = 5'b10011;
    localparam logic [4:0] OP_CLRB = 5'b10100;
    localparam logic [4:0] OP_CALL = 5'b10101;
    localparam logic [4:0] OP_RET  = 5'b10110;

    localparam logic STACK_ON = (RAM_STACK != 0);

    state_t     state_q, state_d;
    logic [1:0] step_q, step_d;
    logic       last_s;
    logic       bit_s;

    // State and microstep registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_INIT;
            step_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Next-state logic and strobe decode from {state, step, OPCODE, STATUS}.
    always_comb begin
        state_d          = state_q;
        step_d           = step_q;
        last_s           = 1'b1;
        bit_s            = STATUS[STATUS_SEL];
        ALU_OPERATION    = 4'd0;
        INC_PROGCOUNT    = 1'b0;
        CLR_PROGCOUNT    = 1'b0;
        WRITE_PROGCOUNT  = 1'b0;
        READ_PROGCOUNT   = 1'b0;
        WRITE_INSTREG    = 1'b0;
        WRITE_REGS       = 1'b0;
        USE_IMMEDIATE    = 1'b0;
        USE_DISPLACEMENT = 1'b0;
        WRITE_MEM        = 1'b0;
        READ_MEM         = 1'b0;
        WRITE_MEMADDR    = 1'b0;
        WRITE_STATREG    = 1'b0;
        CLR_STATBIT      = 1'b0;
        SET_STATBIT      = 1'b0;
        PRESET_STACKPTR  = 1'b0;
        INC_STACKPTR     = 1'b0;
        DEC_STACKPTR     = 1'b0;
        READ_STACKPTR    = 1'b0;
        HALTED           = 1'b0;
        // Reset masks every strobe, including the INIT ones, while it is held.
        if (RESET) begin
            state_d = ST_INIT;
            step_d  = 2'd0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    CLR_PROGCOUNT   = 1'b1;
                    PRESET_STACKPTR = 1'b1;
                    state_d         = ST_FETCH;
                end
                ST_FETCH: begin
`ifdef SINGLE_STEP_EN
                    if (STEP) begin
                        WRITE_INSTREG = 1'b1;
                        INC_PROGCOUNT = 1'b1;
                        state_d       = ST_EXEC;
                        step_d        = 2'd0;
                    end else begin
                        state_d = ST_FETCH;
                    end
`else
                    WRITE_INSTREG = 1'b1;
                    INC_PROGCOUNT = 1'b1;
                    state_d       = ST_EXEC;
                    step_d        = 2'd0;
`endif
                end
                ST_EXEC: begin
                    casez (OPCODE)
                        OP_MOV: begin
                            ALU_OPERATION = ALU_PASS_B;
                            WRITE_REGS    = 1'b1;
                        end
                        OP_LDI: begin
                            ALU_OPERATION = ALU_PASS_B;
                            USE_IMMEDIATE = 1'b1;
                            WRITE_REGS    = 1'b1;
                        end
                        OP_LD, OP_ST: begin
                            last_s = (step_q == 2'd1);
                            if (step_q == 2'd0) begin
                                ALU_OPERATION = ALU_PASS_B;
                                WRITE_MEMADDR = 1'b1;
                            end else if (OPCODE == OP_LD) begin
                                READ_MEM   = 1'b1;
                                WRITE_REGS = 1'b1;
                            end else begin
                                ALU_OPERATION = ALU_PASS_A;
                                WRITE_MEM     = 1'b1;
                            end
                        end
                        5'b01???: begin
                            ALU_OPERATION = {1'b0, OPCODE[2:0]};
                            WRITE_REGS    = 1'b1;
                            WRITE_STATREG = 1'b1;
                        end
                        OP_JMP, OP_BRS, OP_BRC: begin
                            if ((OPCODE == OP_JMP) || ((OPCODE == OP_BRS) && bit_s) ||
                                ((OPCODE == OP_BRC) && !bit_s)) begin
                                ALU_OPERATION   = ALU_PASS_B;
                                USE_IMMEDIATE   = 1'b1;
                                WRITE_PROGCOUNT = 1'b1;
                            end else begin
                                ALU_OPERATION = 4'd0;
                            end
                        end
                        OP_SETB: SET_STATBIT = 1'b1;
                        OP_CLRB: CLR_STATBIT = 1'b1;
                        OP_CALL, OP_RET: begin
                            // With the stack disabled both fall through as a one-cycle NOP.
                            if (STACK_ON) begin
                                last_s = (step_q == 2'd2);
                                case (step_q)
                                    2'd0: begin
                                        INC_STACKPTR  = (OPCODE == OP_RET);
                                        READ_STACKPTR = (OPCODE == OP_CALL);
                                        WRITE_MEMADDR = (OPCODE == OP_CALL);
                                    end
                                    2'd1: begin
                                        if (OPCODE == OP_CALL) begin
                                            READ_PROGCOUNT = 1'b1;
                                            WRITE_MEM      = 1'b1;
                                            DEC_STACKPTR   = 1'b1;
                                        end else begin
                                            READ_STACKPTR = 1'b1;
                                            WRITE_MEMADDR = 1'b1;
                                        end
                                    end
                                    default: begin
                                        WRITE_PROGCOUNT = 1'b1;
                                        if (OPCODE == OP_CALL) begin
                                            ALU_OPERATION = ALU_PASS_B;
                                            USE_IMMEDIATE = 1'b1;
                                        end else begin
                                            READ_MEM = 1'b1;
                                        end
                                    end
                                endcase
                            end else begin
                                last_s = 1'b1;
                            end
                        end
                        default: last_s = 1'b1;
                    endcase
                    if (OPCODE == OP_HALT) begin
                        state_d = ST_HALT;
                        step_d  = 2'd0;
                    end else if (last_s) begin
                        state_d = ST_FETCH;
                        step_d  = 2'd0;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
                ST_HALT: HALTED = 1'b1;
                default: state_d = ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an instruction-level model queues the expected
// per-cycle strobe vector and a negedge monitor compares whatever the DUT drives.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] opcode = 5'd0;
    logic [7:0] status = 8'd0;
    logic [2:0] status_sel = 3'd0;
    logic [3:0] alu_op;
    logic inc_pc, clr_pc, wr_pc, rd_pc, wr_ir, wr_regs, use_imm, use_disp;
    logic wr_mem, rd_mem, wr_ma, wr_stat, clr_sb, set_sb, pre_sp, inc_sp, dec_sp, rd_sp, halted;

    control_unit dut (
        .CLK(clk), .RESET(rst), .OPCODE(opcode), .STATUS(status), .STATUS_SEL(status_sel),
`ifdef SINGLE_STEP_EN
        .STEP(1'b1),
`endif
        .ALU_OPERATION(alu_op), .INC_PROGCOUNT(inc_pc), .CLR_PROGCOUNT(clr_pc),
        .WRITE_PROGCOUNT(wr_pc), .READ_PROGCOUNT(rd_pc), .WRITE_INSTREG(wr_ir),
        .WRITE_REGS(wr_regs), .USE_IMMEDIATE(use_imm), .USE_DISPLACEMENT(use_disp),
        .WRITE_MEM(wr_mem), .READ_MEM(rd_mem), .WRITE_MEMADDR(wr_ma),
        .WRITE_STATREG(wr_stat), .CLR_STATBIT(clr_sb), .SET_STATBIT(set_sb),
        .PRESET_STACKPTR(pre_sp), .INC_STACKPTR(inc_sp), .DEC_STACKPTR(dec_sp),
        .READ_STACKPTR(rd_sp), .HALTED(halted)
    );

    always #5 clk = ~clk;

    // Bit map: [22:19] ALU code, [18] HALTED, [17:0] strobes.
    localparam logic [22:0] V_INCPC = 23'h1 << 0,  V_CLRPC = 23'h1 << 1,  V_WPC  = 23'h1 << 2;
    localparam logic [22:0] V_RPC   = 23'h1 << 3,  V_WIR   = 23'h1 << 4,  V_WREG = 23'h1 << 5;
    localparam logic [22:0] V_IMM   = 23'h1 << 6,  V_WMEM  = 23'h1 << 8,  V_RMEM = 23'h1 << 9;
    localparam logic [22:0] V_WMA   = 23'h1 << 10, V_WSTAT = 23'h1 << 11, V_CLRB = 23'h1 << 12;
    localparam logic [22:0] V_SETB  = 23'h1 << 13, V_PSP   = 23'h1 << 14, V_ISP  = 23'h1 << 15;
    localparam logic [22:0] V_DSP   = 23'h1 << 16, V_RSP   = 23'h1 << 17, V_HALT = 23'h1 << 18;
    localparam logic [22:0] V_INIT  = V_CLRPC | V_PSP;
    localparam logic [22:0] V_FETCH = V_WIR | V_INCPC;

    logic [22:0] act;
    assign act = {alu_op, halted, rd_sp, dec_sp, inc_sp, pre_sp, set_sb, clr_sb, wr_stat,
                  wr_ma, rd_mem, wr_mem, use_disp, use_imm, wr_regs, wr_ir, rd_pc, wr_pc,
                  clr_pc, inc_pc};

    logic [22:0] exp_q[$];
    logic [22:0] seq[$];
    int checks = 0;
    int errors = 0;
    int cycle_n = 0;

    function automatic logic [22:0] alu(input logic [3:0] code);
        return {code, 19'd0};
    endfunction

    // Reference: the per-cycle EXEC strobe list of one instruction, straight from the opcode table.
    function automatic void build_seq(input logic [4:0] op, input logic [7:0] st, input logic [2:0] sel);
        logic [22:0] jmp;
        logic        b;
        jmp = alu(4'b1111) | V_IMM | V_WPC;
        b   = st[sel];
        seq.delete();
        if (op == 5'd2)                        seq.push_back(alu(4'b1111) | V_WREG);
        else if (op == 5'd3)                   seq.push_back(alu(4'b1111) | V_IMM | V_WREG);
        else if (op == 5'd4) begin
            seq.push_back(alu(4'b1111) | V_WMA);
            seq.push_back(V_RMEM | V_WREG);
        end else if (op == 5'd5) begin
            seq.push_back(alu(4'b1111) | V_WMA);
            seq.push_back(alu(4'b1110) | V_WMEM);
        end else if (op >= 5'd8 && op <= 5'd15) seq.push_back(alu({1'b0, op[2:0]}) | V_WREG | V_WSTAT);
        else if (op == 5'd16)                  seq.push_back(jmp);
        else if (op == 5'd17)                  seq.push_back(b ? jmp : 23'd0);
        else if (op == 5'd18)                  seq.push_back(b ? 23'd0 : jmp);
        else if (op == 5'd19)                  seq.push_back(V_SETB);
        else if (op == 5'd20)                  seq.push_back(V_CLRB);
        else if (op == 5'd21) begin
            seq.push_back(V_RSP | V_WMA);
            seq.push_back(V_RPC | V_WMEM | V_DSP);
            seq.push_back(jmp);
        end else if (op == 5'd22) begin
            seq.push_back(V_ISP);
            seq.push_back(V_RSP | V_WMA);
            seq.push_back(V_RMEM | V_WPC);
        end else                               seq.push_back(23'd0);
    endfunction

    task automatic cyc(input logic [22:0] v);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [4:0] op, input logic [7:0] st, input logic [2:0] sel);
        int n;
        opcode     = op;
        status     = st;
        status_sel = sel;
        build_seq(op, st, sel);
        n = seq.size();
        cyc(V_FETCH);
        for (int i = 0; i < n; i++) cyc(seq[i]);
    endtask

    // Monitor: every cycle the DUT drives a strobe vector; compare against the oldest expectation.
    always @(negedge clk) begin
        cycle_n++;
        if (exp_q.size() != 0) begin
            logic [22:0] e;
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL strobes cycle %0d op %b: got %h expected %h", cycle_n, opcode, act, e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] op;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cyc(23'd0);
        rst = 1'b0;
        cyc(V_INIT);
        run(5'b00011, 8'h00, 3'd0);
        run(5'b00100, 8'h00, 3'd0);
        run(5'b00101, 8'h00, 3'd0);
        run(5'b10001, 8'h01, 3'd0);
        run(5'b10001, 8'h00, 3'd0);
        run(5'b10010, 8'h00, 3'd0);
        run(5'b10010, 8'h80, 3'd7);
        run(5'b10101, 8'h00, 3'd0);
        run(5'b10110, 8'h00, 3'd0);
        for (int i = 0; i < 300; i++) begin
            do op = 5'($urandom_range(0, 31)); while (op == 5'b00001);
            run(op, 8'($urandom), 3'($urandom_range(0, 7)));
        end
        // Reset in the middle of a CALL aborts it.
        opcode = 5'b10101;
        cyc(V_FETCH);
        cyc(V_RSP | V_WMA);
        rst = 1'b1;
        cyc(23'd0);
        cyc(23'd0);
        rst = 1'b0;
        cyc(V_INIT);
        run(5'b00010, 8'h00, 3'd0);
        run(5'b00001, 8'h00, 3'd0);
        for (int i = 0; i < 20; i++) begin
            opcode = 5'($urandom);
            status = 8'($urandom);
            cyc(V_HALT);
        end
        rst = 1'b1;
        cyc(23'd0);
        rst = 1'b0;
        cyc(V_INIT);
        run(5'b00000, 8'h00, 3'd0);
        run(5'b01101, 8'h00, 3'd0);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
